sdram_bank_model_rsp: RTL and testbench
=======================================

// Module: sdram_bank_model_rsp
// PURPOSE
//  Device-side responder for the mem_ctrl command bus (command/RA/CA/cs_n/DQ).
//  Decodes ACT/READ/WRITE/PRE/REFRESH and holds a 16-row x 2^COL_BITS x 32b array.
//  Drives read data onto DQ after CAS latency and captures write data from DQ.
//  Checks row state, bank timing and refresh interval; flags protocol errors for the TB scoreboard.
// PARAMETERS
//  COL_BITS   12   column address bits used; CA[COL_BITS-1:0] indexes the array
//  CL          2   cycles from READ edge to DQ-valid edge
//  TRCD        5   min cycles from ACT to READ/WRITE
//  TRP         2   cycles PRE occupies before the bank is CLOSED
//  TRFC        5   cycles REFRESH occupies before the bank is CLOSED
//  TREFI_WARN 300  interval count at which refresh_due asserts
//  TREFI_MAX  340  interval count at which a missed refresh is flagged
// PORTS
//  clk        in    1   clock, all sampling on posedge
//  rst_n      in    1   asynchronous active-low reset
//  cs_n       in    1   chip select; high = command treated as NOP
//  command    in    3   0 NOP,1 ACT,2 READ,3 WRITE,4 PRE,5 REFRESH,6/7 illegal
//  RA         in    4   row address, used on ACT
//  CA         in    12  column address, used on READ/WRITE
//  DQ         inout 32  data bus; driven only in read-data cycles, else 'z
//  row_open   out   1   bank state is OPEN
//  open_row   out   4   row latched by last ACT
//  rd_vld     out   1   DQ carries read data this cycle
//  refresh_due out  1   interval count >= TREFI_WARN
//  err_pulse  out   1   one-cycle strobe per detected error
//  proto_err  out   1   sticky, set on first error, cleared only by reset
//  err_code   out   3   code of first error (1 NO_ROW,2 ACT_OPEN,3 TIMING,4 REF_OPEN,5 BUS_CONFLICT,6 REF_MISSED,7 ILLEGAL)
// BEHAVIOUR
//  Reset: state CLOSED, open_row 0, all outputs 0, DQ 'z at once, read pipe flushed,
//   interval count 0; array contents not cleared.
//  Valid cmd = !cs_n && command!=NOP, sampled at posedge. Rejected cmds change no state and no array data.
//  FSM CLOSED / ACTIVATING / OPEN / PRECHARGING / REFRESHING. Down-counter cnt:
//   CLOSED: ACT -> latch RA, cnt=TRCD-1, ACTIVATING. REFRESH -> cnt=TRFC-1, REFRESHING.
//    PRE is a legal no-op. READ/WRITE -> NO_ROW.
//   ACTIVATING/PRECHARGING/REFRESHING: any valid cmd -> TIMING. State exits when cnt==0:
//    ACTIVATING->OPEN, others->CLOSED. The cmd after ACT at edge t is legal at edge t+TRCD.
//   OPEN: READ -> read mem[{open_row,CA}] at the cmd edge into a CL-deep pipe.
//    DQ is driven and rd_vld=1 for exactly one cycle, starting edge t+CL.
//    Back-to-back READs give one data word per cycle.
//    WRITE -> write DQ sampled at the cmd edge to mem[{open_row,CA}].
//    PRE -> cnt=TRP-1, PRECHARGING. ACT -> ACT_OPEN (same row or a different row). REFRESH -> REF_OPEN.
//  WRITE while the read pipe is non-empty -> BUS_CONFLICT, write dropped.
//  A PRE or REFRESH with reads in flight still delivers those reads.
//  command 6/7 with cs_n low -> ILLEGAL in any state.
//  Refresh interval: count +1 per cycle, saturates at TREFI_MAX.
//   Reset to 0 on the edge that accepts a REFRESH.
//   Reaching TREFI_MAX -> REF_MISSED, flagged once per interval.
//  Errors: err_pulse is registered and asserts the cycle after the offending edge.
//   If two errors occur on the same edge, err_code records the command error, not REF_MISSED.
//   Later errors pulse but leave err_code unchanged.
//  Address: with COL_BITS<12, upper CA bits are ignored without an error.
// TESTING
//  1 ACT RA=3 @t0; WRITE CA=0x010 DQ=0xDEADBEEF @t0+5; READ CA=0x010 @t0+7 -> rd_vld and DQ=0xDEADBEEF at edge t0+9, DQ 'z at t0+10.
//  2 ACT then READ at t0+4 -> err_code=3, proto_err=1, no rd_vld; READ at t0+5 accepted.
//  3 READ, WRITE at next cycle -> BUS_CONFLICT (5); read data intact; rereading the written addr returns old data.
//  4 No REFRESH for 340 cycles after reset -> refresh_due from cycle 300, err_code=6 at 340.
//    A REFRESH after that clears the count and refresh_due.
//  5 ACT, PRE at +5, READ at +6 -> TIMING; READ at +7 (CLOSED) -> err_pulse but err_code stays 3.
//  6 Four back-to-back READs then rst_n low mid-burst -> DQ 'z immediately, rd_vld=0, row_open=0; array preserved.

Source files
------------

// File: rtl/sdram_bank_model_rsp.sv
// Single-bank SDRAM device responder for the mem_ctrl command bus: decodes commands,
// enforces bank and refresh timing, drives CL-delayed read data on DQ and flags protocol errors.
module sdram_bank_model_rsp #(
    parameter int COL_BITS   = 12,
    parameter int CL         = 2,
    parameter int TRCD       = 5,
    parameter int TRP        = 2,
    parameter int TRFC       = 5,
    parameter int TREFI_WARN = 300,
    parameter int TREFI_MAX  = 340
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic [2:0]  command,
    input  logic [3:0]  RA,
    input  logic [11:0] CA,
    inout  wire  [31:0] DQ,
    output logic        row_open,
    output logic [3:0]  open_row,
    output logic        rd_vld,
    output logic        refresh_due,
    output logic        err_pulse,
    output logic        proto_err,
    output logic [2:0]  err_code
);

    localparam int AW        = 4 + COL_BITS;
    localparam int MEM_DEPTH = 1 << AW;
    localparam int T_LONGEST = (TRCD > TRP) ? ((TRCD > TRFC) ? TRCD : TRFC)
                                            : ((TRP > TRFC) ? TRP : TRFC);
    localparam int CNT_W     = (T_LONGEST > 2) ? $clog2(T_LONGEST) : 1;
    localparam int REF_W     = $clog2(TREFI_MAX + 1);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_REF  = 3'd5;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_NO_ROW     = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN   = 3'd2;
    localparam logic [2:0] ERR_TIMING     = 3'd3;
    localparam logic [2:0] ERR_REF_OPEN   = 3'd4;
    localparam logic [2:0] ERR_BUS_CONF   = 3'd5;
    localparam logic [2:0] ERR_REF_MISSED = 3'd6;
    localparam logic [2:0] ERR_ILLEGAL    = 3'd7;

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'd0,
        ST_ACTIVATING  = 3'd1,
        ST_OPEN        = 3'd2,
        ST_PRECHARGING = 3'd3,
        ST_REFRESHING  = 3'd4
    } bank_state_t;

    bank_state_t            state_r;
    bank_state_t            state_nx_s;
    bank_state_t            eff_state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nx_s;
    logic [3:0]             open_row_r;
    logic [3:0]             open_row_nx_s;

    logic [31:0]            mem_r [MEM_DEPTH];
    logic [AW-1:0]          addr_s;

    logic [CL-1:0]          pipe_vld_r;
    logic [31:0]            pipe_data_r [CL];
    logic                   rd_vld_r;
    logic [31:0]            rd_data_r;
    logic                   pipe_busy_s;

    logic                   cmd_valid_s;
    logic                   rd_accept_s;
    logic                   wr_accept_s;
    logic                   ref_accept_s;
    logic [2:0]             cmd_err_s;

    logic [REF_W-1:0]       ref_cnt_r;
    logic [REF_W-1:0]       ref_cnt_nx_s;
    logic                   ref_missed_s;
    logic                   refresh_due_r;

    logic                   err_any_s;
    logic                   err_pulse_r;
    logic                   proto_err_r;
    logic [2:0]             err_code_r;

    assign cmd_valid_s = !cs_n && (command != CMD_NOP);
    assign addr_s      = {open_row_r, CA[COL_BITS-1:0]};
    assign pipe_busy_s = (|pipe_vld_r) || rd_vld_r;

    // Busy states whose counter has expired already behave as their exit state,
    // so the command arriving on the expiry edge is judged against OPEN/CLOSED.
    always_comb begin
        eff_state_s = state_r;
        case (state_r)
            ST_ACTIVATING:  eff_state_s = (cnt_r == {CNT_W{1'b0}}) ? ST_OPEN : ST_ACTIVATING;
            ST_PRECHARGING: eff_state_s = (cnt_r == {CNT_W{1'b0}}) ? ST_CLOSED : ST_PRECHARGING;
            ST_REFRESHING:  eff_state_s = (cnt_r == {CNT_W{1'b0}}) ? ST_CLOSED : ST_REFRESHING;
            default:        eff_state_s = state_r;
        endcase
    end

    // Command decode: next state, counter reload, accepted operations and command errors
    always_comb begin
        state_nx_s    = eff_state_s;
        cnt_nx_s      = (cnt_r != {CNT_W{1'b0}}) ? (cnt_r - CNT_W'(1)) : {CNT_W{1'b0}};
        open_row_nx_s = open_row_r;
        rd_accept_s   = 1'b0;
        wr_accept_s   = 1'b0;
        ref_accept_s  = 1'b0;
        cmd_err_s     = ERR_NONE;
        if (!cmd_valid_s) begin
            cmd_err_s = ERR_NONE;
        end else if (command > CMD_REF) begin
            cmd_err_s = ERR_ILLEGAL;
        end else begin
            case (eff_state_s)
                ST_CLOSED: begin
                    case (command)
                        CMD_ACT: begin
                            open_row_nx_s = RA;
                            cnt_nx_s      = CNT_W'(TRCD - 1);
                            state_nx_s    = ST_ACTIVATING;
                        end
                        CMD_REF: begin
                            ref_accept_s = 1'b1;
                            cnt_nx_s     = CNT_W'(TRFC - 1);
                            state_nx_s   = ST_REFRESHING;
                        end
                        CMD_RD, CMD_WR: cmd_err_s = ERR_NO_ROW;
                        default:        cmd_err_s = ERR_NONE;
                    endcase
                end
                ST_OPEN: begin
                    case (command)
                        CMD_RD: rd_accept_s = 1'b1;
                        CMD_WR: begin
                            if (pipe_busy_s) begin
                                cmd_err_s = ERR_BUS_CONF;
                            end else begin
                                wr_accept_s = 1'b1;
                            end
                        end
                        CMD_PRE: begin
                            cnt_nx_s   = CNT_W'(TRP - 1);
                            state_nx_s = ST_PRECHARGING;
                        end
                        CMD_ACT: cmd_err_s = ERR_ACT_OPEN;
                        CMD_REF: cmd_err_s = ERR_REF_OPEN;
                        default: cmd_err_s = ERR_NONE;
                    endcase
                end
                default: cmd_err_s = ERR_TIMING;
            endcase
        end
    end

    // Bank state, timing counter and latched row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_CLOSED;
            cnt_r      <= {CNT_W{1'b0}};
            open_row_r <= 4'd0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            open_row_r <= open_row_nx_s;
        end
    end

    // Storage array; intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[addr_s] <= DQ;
        end
    end

    // Read pipe valid bits: flushed by reset so DQ releases immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r <= {CL{1'b0}};
            rd_vld_r   <= 1'b0;
        end else begin
            pipe_vld_r[0] <= rd_accept_s;
            for (int i = 1; i < CL; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
            end
            rd_vld_r <= pipe_vld_r[CL-1];
        end
    end

    // Read pipe data; only meaningful alongside the matching valid bit
    always_ff @(posedge clk) begin
        if (rd_accept_s) begin
            pipe_data_r[0] <= mem_r[addr_s];
        end
        for (int i = 1; i < CL; i++) begin
            pipe_data_r[i] <= pipe_data_r[i-1];
        end
        rd_data_r <= pipe_data_r[CL-1];
    end

    assign DQ = rd_vld_r ? rd_data_r : {32{1'bz}};

    // Refresh interval: saturating count, missed refresh reported once on reaching the limit
    always_comb begin
        ref_missed_s = 1'b0;
        if (ref_accept_s) begin
            ref_cnt_nx_s = {REF_W{1'b0}};
        end else if (ref_cnt_r == REF_W'(TREFI_MAX)) begin
            ref_cnt_nx_s = ref_cnt_r;
        end else begin
            ref_cnt_nx_s = ref_cnt_r + REF_W'(1);
            ref_missed_s = (ref_cnt_r == REF_W'(TREFI_MAX - 1));
        end
    end

    // Refresh interval register and warning flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_r     <= {REF_W{1'b0}};
            refresh_due_r <= 1'b0;
        end else begin
            ref_cnt_r     <= ref_cnt_nx_s;
            refresh_due_r <= (ref_cnt_nx_s >= REF_W'(TREFI_WARN));
        end
    end

    assign err_any_s = (cmd_err_s != ERR_NONE) || ref_missed_s;

    // Error reporting: pulse per error, first code sticks; command errors outrank REF_MISSED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_r <= 1'b0;
            proto_err_r <= 1'b0;
            err_code_r  <= ERR_NONE;
        end else begin
            err_pulse_r <= err_any_s;
            if (err_any_s && !proto_err_r) begin
                proto_err_r <= 1'b1;
                err_code_r  <= (cmd_err_s != ERR_NONE) ? cmd_err_s : ERR_REF_MISSED;
            end
        end
    end

    assign row_open    = (state_r == ST_OPEN);
    assign open_row    = open_row_r;
    assign rd_vld      = rd_vld_r;
    assign refresh_due = refresh_due_r;
    assign err_pulse   = err_pulse_r;
    assign proto_err   = proto_err_r;
    assign err_code    = err_code_r;

endmodule

// File: tb/tb_sdram_bank_model_rsp.sv
// Directed bench for sdram_bank_model_rsp: an edge-time model of the bank rules is
// compared against the DUT on every negedge, plus hand-computed literal checkpoints.
module tb_sdram_bank_model_rsp;

    localparam int CL   = 2;
    localparam int TRCD = 5;
    localparam int TRP  = 2;
    localparam int TRFC = 5;
    localparam int WARN = 300;
    localparam int RMAX = 340;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic [2:0]  command = 3'd0;
    logic [3:0]  RA = 4'd0;
    logic [11:0] CA = 12'd0;
    logic [31:0] tb_dq = 32'd0;
    wire         tb_en;
    wire  [31:0] DQ;
    logic        row_open;
    logic [3:0]  open_row;
    logic        rd_vld;
    logic        refresh_due;
    logic        err_pulse;
    logic        proto_err;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;

    // Edge-time model: commands are judged by edge stamps rather than a state machine
    int          e = 0;
    int          ready_e = 0;
    int          last_ref_e = 0;
    bit          m_open = 1'b0;
    logic [3:0]  m_row = 4'd0;
    logic [31:0] m_mem [int];
    int          rd_due_q [$];
    logic [31:0] rd_dat_q [$];

    logic        exp_row_open = 1'b0;
    logic [3:0]  exp_open_row = 4'd0;
    logic        exp_vld = 1'b0;
    logic [31:0] exp_data = 32'd0;
    logic        exp_due = 1'b0;
    logic        exp_pulse = 1'b0;
    logic        exp_proto = 1'b0;
    logic [2:0]  exp_code = 3'd0;

    assign tb_en = !exp_vld;
    assign DQ = tb_en ? tb_dq : {32{1'bz}};

    sdram_bank_model_rsp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_n        (cs_n),
        .command     (command),
        .RA          (RA),
        .CA          (CA),
        .DQ          (DQ),
        .row_open    (row_open),
        .open_row    (open_row),
        .rd_vld      (rd_vld),
        .refresh_due (refresh_due),
        .err_pulse   (err_pulse),
        .proto_err   (proto_err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at e=%0d got %h want %h", name, e, got, want);
        end
    endtask

    task automatic model_reset();
        e = 0; ready_e = 0; last_ref_e = 0; m_open = 1'b0; m_row = 4'd0;
        rd_due_q.delete(); rd_dat_q.delete();
        exp_row_open = 1'b0; exp_open_row = 4'd0; exp_vld = 1'b0; exp_data = 32'd0;
        exp_due = 1'b0; exp_pulse = 1'b0; exp_proto = 1'b0; exp_code = 3'd0;
    endtask

    task automatic model_edge();
        int err;
        bit acc_ref;
        bit pipe_busy;
        int key;
        err = 0; acc_ref = 1'b0; pipe_busy = 1'b0;
        e++;
        key = int'({m_row, CA});
        foreach (rd_due_q[i]) if (rd_due_q[i] >= e - 1) pipe_busy = 1'b1;
        if (!cs_n && command != 3'd0) begin
            if (command >= 3'd6) err = 7;
            else if (e < ready_e) err = 3;
            else if (!m_open) begin
                case (command)
                    3'd1: begin m_open = 1'b1; m_row = RA; ready_e = e + TRCD; end
                    3'd5: begin acc_ref = 1'b1; ready_e = e + TRFC; end
                    3'd2, 3'd3: err = 1;
                    default: err = 0;
                endcase
            end else begin
                case (command)
                    3'd2: begin rd_due_q.push_back(e + CL); rd_dat_q.push_back(m_mem[key]); end
                    3'd3: if (pipe_busy) err = 5; else m_mem[key] = tb_dq;
                    3'd4: begin m_open = 1'b0; ready_e = e + TRP; end
                    3'd1: err = 2;
                    3'd5: err = 4;
                    default: err = 0;
                endcase
            end
        end
        if (acc_ref) last_ref_e = e;
        exp_due = ((e - last_ref_e) >= WARN);
        exp_pulse = (err != 0) || (!acc_ref && (e - last_ref_e == RMAX));
        if (exp_pulse && !exp_proto) begin
            exp_proto = 1'b1;
            exp_code = (err != 0) ? 3'(err) : 3'd6;
        end
        exp_row_open = m_open && (e >= ready_e);
        exp_open_row = m_row;
        while (rd_due_q.size() > 0 && rd_due_q[0] < e) begin
            void'(rd_due_q.pop_front());
            void'(rd_dat_q.pop_front());
        end
        exp_vld = (rd_due_q.size() > 0) && (rd_due_q[0] == e);
        if (exp_vld) exp_data = rd_dat_q[0];
    endtask

    // Drive one command for one edge, then advance the model on that edge
    task automatic step(input logic cs, input logic [2:0] c, input logic [3:0] ra,
                        input logic [11:0] ca, input logic [31:0] d);
        cs_n = cs; command = c; RA = ra; CA = ca; tb_dq = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [3:0] ra, input logic [11:0] ca,
                       input logic [31:0] d);
        step(1'b0, c, ra, ca, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 3'd0, 4'd0, 12'd0, 32'd0);
    endtask

    task automatic do_reset();
        cs_n = 1'b1; command = 3'd0; tb_dq = 32'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("row_open", 32'(row_open), 32'(exp_row_open));
        chk("open_row", 32'(open_row), 32'(exp_open_row));
        chk("rd_vld", 32'(rd_vld), 32'(exp_vld));
        chk("refresh_due", 32'(refresh_due), 32'(exp_due));
        chk("err_pulse", 32'(err_pulse), 32'(exp_pulse));
        chk("proto_err", 32'(proto_err), 32'(exp_proto));
        chk("err_code", 32'(err_code), 32'(exp_code));
        if (exp_vld) chk("dq_read", DQ, exp_data);
        else         chk("dq_idle", DQ, tb_dq);
    end

    logic [2:0] bad_cmd  [3];
    logic [2:0] bad_code [3];

    initial begin
        bad_cmd[0] = 3'd1; bad_code[0] = 3'd2;
        bad_cmd[1] = 3'd5; bad_code[1] = 3'd4;
        bad_cmd[2] = 3'd6; bad_code[2] = 3'd7;

        // Reset state
        do_reset();
        chk("rst_row_open", 32'(row_open), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("rst_dq", DQ, 32'd0);

        // 1: write then read with CL latency; deselected WRITE must be ignored
        cmd(3'd1, 4'd3, 12'd0, 32'd0);
        idle(4);
        cmd(3'd3, 4'd0, 12'h010, 32'hDEADBEEF);
        step(1'b1, 3'd3, 4'd0, 12'h010, 32'h12345678);
        cmd(3'd2, 4'd0, 12'h010, 32'd0);
        idle(1);
        chk("t1_pre_vld", 32'(rd_vld), 32'd0);
        idle(1);
        chk("t1_vld", 32'(rd_vld), 32'd1);
        chk("t1_dq", DQ, 32'hDEADBEEF);
        idle(1);
        chk("t1_vld_end", 32'(rd_vld), 32'd0);
        chk("t1_dq_released", DQ, 32'd0);
        chk("t1_no_err", 32'(proto_err), 32'd0);

        // 2: READ one cycle early is TIMING; on time is accepted
        do_reset();
        cmd(3'd1, 4'd3, 12'd0, 32'd0);
        idle(3);
        cmd(3'd2, 4'd0, 12'h010, 32'd0);
        chk("t2_pulse", 32'(err_pulse), 32'd1);
        chk("t2_code", 32'(err_code), 32'd3);
        chk("t2_proto", 32'(proto_err), 32'd1);
        cmd(3'd2, 4'd0, 12'h010, 32'd0);
        chk("t2_pulse_clr", 32'(err_pulse), 32'd0);
        idle(1);
        chk("t2_no_rogue_vld", 32'(rd_vld), 32'd0);
        idle(1);
        chk("t2_vld", 32'(rd_vld), 32'd1);
        chk("t2_dq", DQ, 32'hDEADBEEF);

        // 3: WRITE behind a READ is a bus conflict and is dropped
        do_reset();
        cmd(3'd1, 4'd3, 12'd0, 32'd0);
        idle(4);
        cmd(3'd3, 4'd0, 12'h020, 32'h11111111);
        cmd(3'd2, 4'd0, 12'h020, 32'd0);
        cmd(3'd3, 4'd0, 12'h020, 32'h22222222);
        chk("t3_code", 32'(err_code), 32'd5);
        idle(1);
        chk("t3_dq", DQ, 32'h11111111);
        idle(2);
        cmd(3'd2, 4'd0, 12'h020, 32'd0);
        idle(2);
        chk("t3_reread", DQ, 32'h11111111);

        // 4: refresh interval warning, miss and recovery
        do_reset();
        idle(299);
        chk("t4_due_299", 32'(refresh_due), 32'd0);
        idle(1);
        chk("t4_due_300", 32'(refresh_due), 32'd1);
        idle(39);
        chk("t4_proto_339", 32'(proto_err), 32'd0);
        idle(1);
        chk("t4_pulse_340", 32'(err_pulse), 32'd1);
        chk("t4_code_340", 32'(err_code), 32'd6);
        idle(5);
        chk("t4_once", 32'(err_pulse), 32'd0);
        cmd(3'd5, 4'd0, 12'd0, 32'd0);
        chk("t4_due_clr", 32'(refresh_due), 32'd0);
        cmd(3'd1, 4'd1, 12'd0, 32'd0);
        chk("t4_timing_pulse", 32'(err_pulse), 32'd1);
        chk("t4_code_kept", 32'(err_code), 32'd6);
        idle(TRFC);

        // 5: READ during precharge, then READ on a closed bank keeps the first code
        do_reset();
        cmd(3'd1, 4'd3, 12'd0, 32'd0);
        idle(4);
        cmd(3'd4, 4'd0, 12'd0, 32'd0);
        chk("t5_row_closed", 32'(row_open), 32'd0);
        cmd(3'd2, 4'd0, 12'h010, 32'd0);
        chk("t5_code", 32'(err_code), 32'd3);
        cmd(3'd2, 4'd0, 12'h010, 32'd0);
        chk("t5_pulse", 32'(err_pulse), 32'd1);
        chk("t5_code_kept", 32'(err_code), 32'd3);

        // Remaining error codes while OPEN: ACT_OPEN, REF_OPEN, ILLEGAL
        for (int k = 0; k < 3; k++) begin
            do_reset();
            cmd(3'd1, 4'd7, 12'd0, 32'd0);
            idle(4);
            cmd(bad_cmd[k], 4'd2, 12'd0, 32'd0);
            chk("t_err_code", 32'(err_code), 32'(bad_code[k]));
            chk("t_err_row", 32'(open_row), 32'd7);
        end

        // 6: reset mid-burst releases DQ at once; array survives
        do_reset();
        cmd(3'd1, 4'd3, 12'd0, 32'd0);
        idle(4);
        for (int i = 0; i < 4; i++) cmd(3'd3, 4'd0, 12'h030 + 12'(i), 32'hC0DE0000 + 32'(i));
        for (int i = 0; i < 4; i++) cmd(3'd2, 4'd0, 12'h030 + 12'(i), 32'd0);
        chk("t6_mid_vld", 32'(rd_vld), 32'd1);
        chk("t6_mid_dq", DQ, 32'hC0DE0001);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_vld", 32'(rd_vld), 32'd0);
        chk("t6_rst_row", 32'(row_open), 32'd0);
        chk("t6_rst_dq", DQ, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmd(3'd1, 4'd3, 12'd0, 32'd0);
        idle(4);
        cmd(3'd2, 4'd0, 12'h032, 32'd0);
        idle(2);
        chk("t6_preserved", DQ, 32'hC0DE0002);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
